// File: rtl/block_slot_loader.sv
// Slot-bus initiator: copies a sprite bitmap from a synchronous ROM into a block core's pixel RAM,
// then programs bypass/x0/y0/ctrl. Define BLOCK_SLOT_LOADER_VBLANK_SYNC_EN to hold the copy until vblank.
module block_slot_loader #(
    parameter int CD           = 12,
    parameter int ADDR_WIDTH   = 12,
    parameter int NWORDS       = 4096,
    parameter int VBLANK_START = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [10:0]           x0_in,
    input  logic [10:0]           y0_in,
    input  logic [3:0]            ctrl_in,
    input  logic [10:0]           y,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [CD-1:0]         rom_data,
    output logic                  cs,
    output logic                  write,
    output logic [13:0]           addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam int WW = ADDR_WIDTH + 1;
    localparam logic [WW-1:0]         LAST   = WW'(NWORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(NWORDS - 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_PRIME = 4'd1;
    localparam logic [3:0] S_COPY  = 4'd2;
    localparam logic [3:0] S_REG0  = 4'd3;
    localparam logic [3:0] S_REG1  = 4'd4;
    localparam logic [3:0] S_REG2  = 4'd5;
    localparam logic [3:0] S_REG3  = 4'd6;
    localparam logic [3:0] S_DONE  = 4'd7;
`ifdef BLOCK_SLOT_LOADER_VBLANK_SYNC_EN
    localparam logic [3:0] S_WAIT_VB = 4'd8;
    localparam logic [10:0] VB_Y     = 11'(VBLANK_START);
`else
    // Frame position only matters when the copy is synchronised to vblank.
    logic unused_y;
    assign unused_y = ^y;
`endif

    logic [3:0]    state_q, state_d;
    logic [WW-1:0] w_q, w_d;
    logic [WW-1:0] w_inc;
    logic [10:0]   x0_q, x0_d, y0_q, y0_d;
    logic [3:0]    ctrl_q, ctrl_d;

    assign w_inc = w_q + WW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d   = x0_in;
                    y0_d   = y0_in;
                    ctrl_d = ctrl_in;
                    w_d    = '0;
`ifdef BLOCK_SLOT_LOADER_VBLANK_SYNC_EN
                    state_d = S_WAIT_VB;
`else
                    state_d = S_PRIME;
`endif
                end
            end
`ifdef BLOCK_SLOT_LOADER_VBLANK_SYNC_EN
            S_WAIT_VB: if (y >= VB_Y) state_d = S_PRIME;
`endif
            S_PRIME: state_d = S_COPY;
            // Counter is one bit wider than the RAM address so a full-size copy ends without wrapping.
            S_COPY: begin
                if (w_q == LAST) state_d = S_REG0;
                else             w_d     = w_inc;
            end
            S_REG0:  state_d = S_REG1;
            S_REG1:  state_d = S_REG2;
            S_REG2:  state_d = S_REG3;
            S_REG3:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rom_addr = '0;
        cs       = 1'b0;
        write    = 1'b0;
        addr     = '0;
        wr_data  = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
`ifdef BLOCK_SLOT_LOADER_VBLANK_SYNC_EN
            S_WAIT_VB: busy = 1'b1;
`endif
            S_PRIME: busy = 1'b1;
            // ROM runs one word ahead of the write; the look-ahead sticks at the last word.
            S_COPY: begin
                busy     = 1'b1;
                cs       = 1'b1;
                write    = 1'b1;
                addr     = {1'b0, 13'(w_q[ADDR_WIDTH-1:0])};
                wr_data  = 32'(rom_data);
                rom_addr = (w_q == LAST) ? LAST_A : w_inc[ADDR_WIDTH-1:0];
            end
            S_REG0: begin
                busy  = 1'b1;
                cs    = 1'b1;
                write = 1'b1;
                addr  = 14'h2000;
            end
            S_REG1: begin
                busy    = 1'b1;
                cs      = 1'b1;
                write   = 1'b1;
                addr    = 14'h2001;
                wr_data = 32'(x0_q);
            end
            S_REG2: begin
                busy    = 1'b1;
                cs      = 1'b1;
                write   = 1'b1;
                addr    = 14'h2002;
                wr_data = 32'(y0_q);
            end
            S_REG3: begin
                busy    = 1'b1;
                cs      = 1'b1;
                write   = 1'b1;
                addr    = 14'h2003;
                wr_data = 32'(ctrl_q);
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_block_slot_loader.sv
// Directed bench for block_slot_loader: an 8-word instance for sequencing/timing and a
// 4096-word instance for the full-range address boundary.
module tb_block_slot_loader;
    localparam int N = 8;
`ifdef BLOCK_SLOT_LOADER_VBLANK_SYNC_EN
    localparam int NW = 1;
`else
    localparam int NW = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, start_b;
    logic [10:0] x0_in, y0_in, y;
    logic [3:0]  ctrl_in;

    logic [11:0] rom_addr, rom_data;
    logic        cs, write, busy, done;
    logic [13:0] addr;
    logic [31:0] wr_data;

    logic [11:0] rom_addr_b, rom_data_b;
    logic        cs_b, write_b, busy_b, done_b;
    logic [13:0] addr_b;
    logic [31:0] wr_data_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [10:0] ex0, ey0;
    logic [3:0]  ectrl;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data   <= 12'h100 + rom_addr;
        rom_data_b <= rom_addr_b;
    end

    block_slot_loader #(.CD(12), .ADDR_WIDTH(12), .NWORDS(N), .VBLANK_START(480)) dut (
        .clk(clk), .reset(reset), .start(start), .x0_in(x0_in), .y0_in(y0_in),
        .ctrl_in(ctrl_in), .y(y), .rom_addr(rom_addr), .rom_data(rom_data),
        .cs(cs), .write(write), .addr(addr), .wr_data(wr_data), .busy(busy), .done(done));

    block_slot_loader #(.CD(12), .ADDR_WIDTH(12), .NWORDS(4096), .VBLANK_START(480)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .x0_in(x0_in), .y0_in(y0_in),
        .ctrl_in(ctrl_in), .y(y), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .cs(cs_b), .write(write_b), .addr(addr_b), .wr_data(wr_data_b), .busy(busy_b), .done(done_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected bus state for cycle c after the accepted start, nwait vblank-wait cycles first.
    task automatic check_cycle(input int c, input int nwait);
        logic [31:0] e_cs, e_addr, e_data, e_busy, e_done, e_rom;
        int r, w;
        e_cs = 0; e_addr = 0; e_data = 0; e_busy = 0; e_done = 0; e_rom = 0;
        r = c - nwait;
        if (c >= 1 && c <= nwait) e_busy = 1;
        else if (r == 1) e_busy = 1;
        else if (r >= 2 && r <= N + 1) begin
            w = r - 2;
            e_cs = 1; e_busy = 1;
            e_addr = 32'(w);
            e_data = 32'h100 + 32'(w);
            e_rom  = (w + 1 > N - 1) ? 32'(N - 1) : 32'(w + 1);
        end else if (r >= N + 2 && r <= N + 5) begin
            e_cs = 1; e_busy = 1;
            e_addr = 32'h2000 + 32'(r - N - 2);
            case (r - N - 2)
                1: e_data = 32'(ex0);
                2: e_data = 32'(ey0);
                3: e_data = 32'(ectrl);
                default: e_data = 0;
            endcase
        end else if (r == N + 6) e_done = 1;
        chk($sformatf("c%0d_cs", c), 32'(cs), e_cs);
        chk($sformatf("c%0d_write", c), 32'(write), e_cs);
        chk($sformatf("c%0d_addr", c), 32'(addr), e_addr);
        chk($sformatf("c%0d_wr_data", c), wr_data, e_data);
        chk($sformatf("c%0d_busy", c), 32'(busy), e_busy);
        chk($sformatf("c%0d_done", c), 32'(done), e_done);
        chk($sformatf("c%0d_rom_addr", c), 32'(rom_addr), e_rom);
    endtask

    task automatic launch(input logic [10:0] x, input logic [10:0] yy, input logic [3:0] ct);
        @(negedge clk);
        x0_in = x; y0_in = yy; ctrl_in = ct; start = 1'b1;
        ex0 = x; ey0 = yy; ectrl = ct;
    endtask

    task automatic check_run(input int inject, input bit b2b, input int nwait);
        int dones = 0;
        for (int c = 1; c <= N + 7 + nwait; c++) begin
            @(negedge clk);
            start = 1'b0;
            check_cycle(c, nwait);
            if (done) dones++;
            if (c == inject) start = 1'b1;
            if (b2b && c >= N + 6 + nwait) begin
                start = 1'b1; x0_in = 11'd7; y0_in = 11'd9; ctrl_in = 4'd12;
            end
        end
        chk("done_pulses", dones, 1);
    endtask

    initial begin
        int nwr, errs;
        logic [13:0] prev;
        bit got_reg;
        reset = 1'b1; start = 1'b0; start_b = 1'b0;
        x0_in = '0; y0_in = '0; ctrl_in = '0;
        ex0 = '0; ey0 = '0; ectrl = '0;
        y = (NW != 0) ? 11'd480 : 11'd300;
        repeat (2) @(negedge clk);
        chk("rst_cs", 32'(cs), 0);
        chk("rst_write", 32'(write), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        reset = 1'b0;

        // Basic sequence
        launch(11'd100, 11'd50, 4'd3);
        check_run(0, 1'b0, NW);

        // start mid-copy must be ignored
        launch(11'd100, 11'd50, 4'd3);
        check_run(5 + NW, 1'b0, NW);

        // Reset during COPY at word 4, then a clean restart
        launch(11'd100, 11'd50, 4'd3);
        for (int c = 1; c <= 6 + NW; c++) begin
            @(negedge clk);
            start = 1'b0;
            check_cycle(c, NW);
        end
        reset = 1'b1;
        #1;
        chk("mid_rst_cs", 32'(cs), 0);
        chk("mid_rst_write", 32'(write), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_cs", 32'(cs), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        launch(11'd21, 11'd22, 4'd5);
        check_run(0, 1'b0, NW);

        // Back-to-back: start on DONE ignored, start one cycle later accepted
        launch(11'd100, 11'd50, 4'd3);
        check_run(0, 1'b1, NW);
        ex0 = 11'd7; ey0 = 11'd9; ectrl = 4'd12;
        check_run(0, 1'b0, NW);

`ifdef BLOCK_SLOT_LOADER_VBLANK_SYNC_EN
        // Hold until vblank, then the normal sequence
        y = 11'd300;
        launch(11'd100, 11'd50, 4'd3);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("vb_wait_busy", 32'(busy), 1);
            chk("vb_wait_cs", 32'(cs), 0);
            if (i == 10) y = 11'd480;
        end
        check_run(0, 1'b0, 0);
`endif

        // Full 4096-word copy: last RAM write at 0x0FFF, next write is 0x2000
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        nwr = 0; errs = 0; prev = '0; got_reg = 1'b0;
        for (int i = 0; i < 5000 && !got_reg; i++) begin
            @(negedge clk);
            if (cs_b && write_b) begin
                if (!addr_b[13]) begin
                    if (32'(addr_b) != 32'(nwr) || wr_data_b != 32'(nwr & 32'hFFF)) errs++;
                    prev = addr_b;
                    nwr++;
                end else begin
                    got_reg = 1'b1;
                    chk("big_next_addr", 32'(addr_b), 32'h2000);
                end
            end
        end
        if (!got_reg) chk("big_timeout", 0, 1);
        chk("big_last_ram", 32'(prev), 32'h0FFF);
        chk("big_ram_writes", nwr, 4096);
        chk("big_seq_errs", errs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
